// File: rtl/pim_cmd_queue.sv
// -----------------------------------------------------------------------------
// pim_cmd_queue
//
// Buffers PIM commands from the core in a small FIFO and issues them one at a
// time to the DMA engine. Each command is issued with a one-cycle o_dma_en
// pulse. The head entry is then held stable on the DMA field outputs until
// the DMA reports completion (busy rises then falls), or until the DMA fails
// to start within BUSY_TIMEOUT cycles.
//
// Handshake: a command transfers on any rising edge where i_cmd_valid and
// o_cmd_ready are both high. o_cmd_ready depends only on occupancy, never on
// i_cmd_valid. An accepted command with an unsupported funct3 or a zero size
// is consumed, but it is not queued and it sets the sticky error flag.
//
// Parameters
//   DEPTH         command FIFO entries (power of two, >= 2)
//   BUSY_TIMEOUT  cycles allowed in WAIT_BUSY for i_dma_busy to rise (1..255)
//
// Ports
//   i_clk, i_rst_n          clock (rising edge), async active-low reset
//   i_cmd_valid/o_cmd_ready command handshake from the core
//   i_cmd_funct3/_sel_pim/_size/_mem_addr  command fields
//   o_dma_en                one-cycle issue pulse to the DMA
//   o_funct3/_sel_pim/_size/_mem_addr      head fields (0 when idle)
//   i_dma_busy              DMA transfer in progress
//   o_done                  one-cycle pulse per completed command
//   o_err / i_err_clr       sticky error flag and its synchronous clear
//   o_count                 FIFO occupancy
//   o_queue_busy            FIFO non-empty or FSM not idle (core fence)
//   dbg_state               current FSM state (IDLE=0, ISSUE=1,
//                           WAIT_BUSY=2, WAIT_DONE=3)
// -----------------------------------------------------------------------------
module pim_cmd_queue #(
    parameter int DEPTH        = 4,
    parameter int BUSY_TIMEOUT = 15
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,

    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic [2:0]                 i_cmd_funct3,
    input  logic [3:0]                 i_cmd_sel_pim,
    input  logic [12:0]                i_cmd_size,
    input  logic [31:0]                i_cmd_mem_addr,

    output logic                       o_dma_en,
    output logic [2:0]                 o_funct3,
    output logic [3:0]                 o_sel_pim,
    output logic [12:0]                o_size,
    output logic [31:0]                o_mem_addr,
    input  logic                       i_dma_busy,

    output logic                       o_done,
    output logic                       o_err,
    input  logic                       i_err_clr,

    output logic [$clog2(DEPTH):0]     o_count,
    output logic                       o_queue_busy,
    output logic [1:0]                 dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [7:0] TIMEOUT_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_BUSY = 2'd2,
        WAIT_DONE = 2'd3
    } state_t;

    typedef struct packed {
        logic [2:0]  funct3;
        logic [3:0]  sel_pim;
        logic [12:0] size;
        logic [31:0] mem_addr;
    } cmd_t;

    // -------------------------------------------------------------------------
    // Storage and pointers
    // -------------------------------------------------------------------------
    cmd_t            mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    state_t          state;
    logic [7:0]      wait_cnt;
    cmd_t            head_q;
    logic            dma_en_q;
    logic            done_q;
    logic            err_q;

    logic            handshake;
    logic            cmd_legal;
    logic            push;
    logic            illegal_cmd;
    logic            busy_timeout;
    logic            dma_complete;
    logic            pop;
    cmd_t            cmd_in;

    assign cmd_in = '{funct3:   i_cmd_funct3,
                      sel_pim:  i_cmd_sel_pim,
                      size:     i_cmd_size,
                      mem_addr: i_cmd_mem_addr};

    assign o_cmd_ready = (count != CW'(DEPTH));
    assign handshake   = i_cmd_valid && o_cmd_ready;

    // Only read, write and compute opcodes with a non-zero length are queued.
    assign cmd_legal   = ((i_cmd_funct3 == 3'b001) ||
                          (i_cmd_funct3 == 3'b010) ||
                          (i_cmd_funct3 == 3'b100)) &&
                         (i_cmd_size != 13'd0);

    assign push        = handshake && cmd_legal;
    assign illegal_cmd = handshake && !cmd_legal;

    // The head leaves the FIFO only when the FSM returns to IDLE, so the
    // fields presented to the DMA cannot shift under it mid-transfer.
    assign busy_timeout = (state == WAIT_BUSY) && !i_dma_busy &&
                          (wait_cnt == TIMEOUT_LAST);
    assign dma_complete = (state == WAIT_DONE) && !i_dma_busy;
    assign pop          = busy_timeout || dma_complete;

    // Storage is not reset: entries are only ever read after being written.
    always_ff @(posedge i_clk) begin
        if (push) begin
            mem[wr_ptr] <= cmd_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Simultaneous push and pop leaves occupancy unchanged.
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    // -------------------------------------------------------------------------
    // Issue FSM with registered DMA-side outputs
    // -------------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            wait_cnt <= '0;
            head_q   <= '0;
            dma_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    // No bypass: the FIFO must already hold the command.
                    if ((count != '0) && !i_dma_busy) begin
                        state    <= ISSUE;
                        dma_en_q <= 1'b1;
                        head_q   <= mem[rd_ptr];
                    end
                end
                ISSUE: begin
                    state    <= WAIT_BUSY;
                    dma_en_q <= 1'b0;
                    wait_cnt <= '0;
                end
                WAIT_BUSY: begin
                    if (i_dma_busy) begin
                        state <= WAIT_DONE;
                    end else if (wait_cnt == TIMEOUT_LAST) begin
                        // DMA never started: drop the command, error raised
                        // below, and no completion pulse.
                        state  <= IDLE;
                        head_q <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                WAIT_DONE: begin
                    if (!i_dma_busy) begin
                        state  <= IDLE;
                        head_q <= '0;
                        done_q <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    dma_en_q <= 1'b0;
                    head_q   <= '0;
                end
            endcase
        end
    end

    // Sticky error; a new error event takes priority over a clear request.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            err_q <= 1'b0;
        end else if (illegal_cmd || busy_timeout) begin
            err_q <= 1'b1;
        end else if (i_err_clr) begin
            err_q <= 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign o_dma_en     = dma_en_q;
    assign o_funct3     = head_q.funct3;
    assign o_sel_pim    = head_q.sel_pim;
    assign o_size       = head_q.size;
    assign o_mem_addr   = head_q.mem_addr;
    assign o_done       = done_q;
    assign o_err        = err_q;
    assign o_count      = count;
    assign o_queue_busy = (count != '0) || (state != IDLE);
    assign dbg_state    = state;

endmodule

// File: tb/tb_pim_cmd_queue.sv
// -----------------------------------------------------------------------------
// tb_pim_cmd_queue
//
// Bench for pim_cmd_queue (DEPTH=4, BUSY_TIMEOUT=15). Legal commands are
// pushed into exp_q as they are accepted. The monitor pops exp_q on every
// o_dma_en pulse and compares the issued fields, then holds those fields as
// the reference until the command completes. A small DMA model raises busy
// one cycle after each issue pulse and holds it for hold_len cycles. Inputs
// change and outputs are sampled on the falling edge.
// -----------------------------------------------------------------------------
module tb_pim_cmd_queue;

    localparam int DEPTH = 4;
    localparam int BUSY_TIMEOUT = 15;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W = 52;

    // ---------------------------------------------------------------- clock/reset
    logic          clk;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [2:0]    cmd_funct3;
    logic [3:0]    cmd_sel_pim;
    logic [12:0]   cmd_size;
    logic [31:0]   cmd_mem_addr;
    logic          dma_en;
    logic [2:0]    funct3;
    logic [3:0]    sel_pim;
    logic [12:0]   size;
    logic [31:0]   mem_addr;
    logic          dma_busy;
    logic          done;
    logic          err;
    logic          err_clr;
    logic [CW-1:0] count;
    logic          queue_busy;
    logic [1:0]    dbg_state;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    pim_cmd_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_cmd_valid    (cmd_valid),
        .o_cmd_ready    (cmd_ready),
        .i_cmd_funct3   (cmd_funct3),
        .i_cmd_sel_pim  (cmd_sel_pim),
        .i_cmd_size     (cmd_size),
        .i_cmd_mem_addr (cmd_mem_addr),
        .o_dma_en       (dma_en),
        .o_funct3       (funct3),
        .o_sel_pim      (sel_pim),
        .o_size         (size),
        .o_mem_addr     (mem_addr),
        .i_dma_busy     (dma_busy),
        .o_done         (done),
        .o_err          (err),
        .i_err_clr      (err_clr),
        .o_count        (count),
        .o_queue_busy   (queue_busy),
        .dbg_state      (dbg_state)
    );

    // ---------------------------------------------------------------- scoreboard
    logic [W-1:0] exp_q[$];
    logic [W-1:0] cur_cmd;
    bit           active;
    int           n_checks;
    int           n_fail;
    int           cyc;
    int           en_cnt;
    int           done_cnt;
    int           last_en_cyc;

    // ---------------------------------------------------------------- DMA model
    bit dma_force;
    bit dma_force_val;
    bit dma_never;
    bit dma_reset;
    bit dma_pend;
    int hold_len;
    int busy_left;

    initial begin
        dma_busy = 1'b0;
        dma_pend = 0;
        busy_left = 0;
        forever begin
            @(negedge clk);
            if (dma_reset) begin
                dma_busy  = 1'b0;
                dma_pend  = 0;
                busy_left = 0;
            end else if (dma_force) begin
                dma_busy = dma_force_val;
                dma_pend = 0;
            end else begin
                if (dma_busy) begin
                    if (busy_left <= 1) dma_busy = 1'b0;
                    else busy_left--;
                end
                if (dma_pend) begin
                    dma_busy  = 1'b1;
                    busy_left = hold_len;
                    dma_pend  = 0;
                end
                if (dma_en && !dma_never) dma_pend = 1;
            end
        end
    end

    // Monitor: issue order, field stability, issue spacing, done counting.
    initial begin
        cyc = 0;
        en_cnt = 0;
        done_cnt = 0;
        last_en_cyc = -100;
        active = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst_n) begin
                active = 0;
            end else begin
                if (dma_en) begin
                    en_cnt++;
                    n_checks++;
                    if (cyc - last_en_cyc < 4) begin
                        n_fail++;
                        $display("FAIL issue_spacing: got %0d cycles, need >= 4", cyc - last_en_cyc);
                    end
                    last_en_cyc = cyc;
                    n_checks++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL unexpected_dma_en: got pulse with fields %h, expected none",
                                 {funct3, sel_pim, size, mem_addr});
                    end else begin
                        cur_cmd = exp_q.pop_front();
                        if ({funct3, sel_pim, size, mem_addr} !== cur_cmd) begin
                            n_fail++;
                            $display("FAIL issue_fields: got %h expected %h",
                                     {funct3, sel_pim, size, mem_addr}, cur_cmd);
                        end
                    end
                    active = 1;
                end else if (active) begin
                    if (done || err) begin
                        active = 0;
                    end else begin
                        n_checks++;
                        if ({funct3, sel_pim, size, mem_addr} !== cur_cmd) begin
                            n_fail++;
                            $display("FAIL head_stable: got %h expected %h",
                                     {funct3, sel_pim, size, mem_addr}, cur_cmd);
                        end
                    end
                end
                if (done) done_cnt++;
            end
        end
    end

    // ---------------------------------------------------------------- driver tasks
    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic push_cmd(input logic [2:0] f3, input logic [3:0] sel,
                            input logic [12:0] sz, input logic [31:0] ad,
                            input bit with_clr);
        bit ok;
        bit legal;
        legal = ((f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100)) && (sz != 13'd0);
        ok = 0;
        cmd_valid    = 1'b1;
        cmd_funct3   = f3;
        cmd_sel_pim  = sel;
        cmd_size     = sz;
        cmd_mem_addr = ad;
        err_clr      = with_clr;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (cmd_ready) ok = 1;
            @(posedge clk);
            if (ok && legal) exp_q.push_back({f3, sel, sz, ad});
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        err_clr   = 1'b0;
        if (!ok) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_accept: got no handshake in 300 cycles, expected acceptance");
        end
    endtask

    task automatic push_random_legal();
        logic [2:0] f3_tab [3];
        f3_tab[0] = 3'b001;
        f3_tab[1] = 3'b010;
        f3_tab[2] = 3'b100;
        push_cmd(f3_tab[$urandom_range(0, 2)], 4'($urandom_range(0, 15)),
                 13'($urandom_range(1, 8191)), $urandom, 1'b0);
    endtask

    task automatic wait_done_cnt(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (done_cnt < target) begin
            n_fail++;
            $display("FAIL %s: got %0d completions, expected %0d", name, done_cnt, target);
        end
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------------------------------------------------------- tests
    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_checks += 8;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b expected 1", cmd_ready); end
        if (count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", count); end
        if (dma_en !== 1'b0) begin n_fail++; $display("FAIL rst_dma_en: got %b expected 0", dma_en); end
        if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b expected 0", done); end
        if (err !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", err); end
        if ({funct3, sel_pim, size, mem_addr} !== '0) begin
            n_fail++; $display("FAIL rst_fields: got %h expected 0", {funct3, sel_pim, size, mem_addr});
        end
        if (queue_busy !== 1'b0) begin n_fail++; $display("FAIL rst_queue_busy: got %b expected 0", queue_busy); end
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL rst_state: got %0d expected 0", dbg_state); end
        idle_cycles(2);
        rst_n = 1'b1;
        idle_cycles(2);
    endtask

    task automatic test_single_write();
        int e0;
        int d0;
        e0 = en_cnt;
        d0 = done_cnt;
        dma_never = 0;
        hold_len = 10;
        push_cmd(3'b001, 4'd3, 13'd8, 32'h100, 1'b0);
        n_checks += 3;
        if (dma_en !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass: got dma_en %b expected 0", dma_en); end
        if (count !== 3'd1) begin n_fail++; $display("FAIL single_count1: got %0d expected 1", count); end
        if (queue_busy !== 1'b1) begin n_fail++; $display("FAIL single_qbusy: got %b expected 1", queue_busy); end
        @(negedge clk);
        n_checks += 2;
        if (dma_en !== 1'b1) begin n_fail++; $display("FAIL single_issue_time: got dma_en %b expected 1", dma_en); end
        if ({funct3, sel_pim, size, mem_addr} !== {3'b001, 4'd3, 13'd8, 32'h100}) begin
            n_fail++;
            $display("FAIL single_fields: got %h expected %h",
                     {funct3, sel_pim, size, mem_addr}, {3'b001, 4'd3, 13'd8, 32'h100});
        end
        wait_done_cnt(d0 + 1, 40, "single_done");
        n_checks += 3;
        if (count !== '0) begin n_fail++; $display("FAIL single_count0: got %0d expected 0", count); end
        if (en_cnt - e0 != 1) begin n_fail++; $display("FAIL single_en_once: got %0d pulses expected 1", en_cnt - e0); end
        if (queue_busy !== 1'b0) begin n_fail++; $display("FAIL single_qbusy_end: got %b expected 0", queue_busy); end
        idle_cycles(3);
    endtask

    task automatic test_fill();
        int d0;
        logic [2:0]  f3_tab [3];
        d0 = done_cnt;
        f3_tab[0] = 3'b001;
        f3_tab[1] = 3'b010;
        f3_tab[2] = 3'b100;
        dma_force = 1;
        dma_force_val = 1;
        idle_cycles(2);
        for (int i = 0; i < DEPTH; i++) push_random_legal();
        n_checks += 2;
        if (count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d expected 4", count); end
        if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", cmd_ready); end
        // Present the fifth command while full and busy: it must be held.
        cmd_valid    = 1'b1;
        cmd_funct3   = f3_tab[$urandom_range(0, 2)];
        cmd_sel_pim  = 4'($urandom_range(0, 15));
        cmd_size     = 13'($urandom_range(1, 8191));
        cmd_mem_addr = $urandom;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (count !== 3'd4 || cmd_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL fill_held: got count %0d ready %b expected 4/0", count, cmd_ready);
            end
        end
        dma_force = 0;
        hold_len = 3;
        push_cmd(cmd_funct3, cmd_sel_pim, cmd_size, cmd_mem_addr, 1'b0);
        wait_done_cnt(d0 + 5, 300, "fill_done");
        n_checks += 2;
        if (exp_q.size() != 0) begin n_fail++; $display("FAIL fill_drained: got %0d left expected 0", exp_q.size()); end
        if (count !== '0) begin n_fail++; $display("FAIL fill_count0: got %0d expected 0", count); end
        idle_cycles(3);
    endtask

    task automatic test_illegal();
        int e0;
        e0 = en_cnt;
        push_cmd(3'b011, 4'd1, 13'd8, 32'h200, 1'b0);
        n_checks += 2;
        if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_f3_err: got %b expected 1", err); end
        if (count !== '0) begin n_fail++; $display("FAIL illegal_f3_count: got %0d expected 0", count); end
        push_cmd(3'b001, 4'd2, 13'd0, 32'h300, 1'b0);
        n_checks += 2;
        if (count !== '0) begin n_fail++; $display("FAIL illegal_size_count: got %0d expected 0", count); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_sticky: got %b expected 1", err); end
        idle_cycles(6);
        n_checks += 2;
        if (en_cnt != e0) begin n_fail++; $display("FAIL illegal_no_issue: got %0d pulses expected 0", en_cnt - e0); end
        if (err !== 1'b1) begin n_fail++; $display("FAIL illegal_hold: got %b expected 1", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b expected 0", err); end
        // Error event and clear in the same cycle: the error must win.
        push_cmd(3'b111, 4'd5, 13'd4, 32'h400, 1'b1);
        n_checks++;
        if (err !== 1'b1) begin n_fail++; $display("FAIL err_set_wins: got %b expected 1", err); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        n_checks++;
        if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear2: got %b expected 0", err); end
        idle_cycles(2);
    endtask

    task automatic test_timeout();
        int d0;
        int n;
        d0 = done_cnt;
        dma_never = 1;
        push_random_legal();
        n = 0;
        while (dma_en !== 1'b1 && n < 10) begin
            @(negedge clk);
            n++;
        end
        n_checks++;
        if (dma_en !== 1'b1) begin n_fail++; $display("FAIL timeout_issue: got no dma_en, expected one"); end
        for (int k = 1; k <= BUSY_TIMEOUT + 1; k++) begin
            @(negedge clk);
            if (k == BUSY_TIMEOUT) begin
                n_checks++;
                if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got err %b at cycle %0d expected 0", err, k); end
            end
        end
        n_checks += 3;
        if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b expected 1", err); end
        if (count !== '0) begin n_fail++; $display("FAIL timeout_pop: got %0d expected 0", count); end
        if (done_cnt != d0) begin n_fail++; $display("FAIL timeout_no_done: got %0d expected 0", done_cnt - d0); end
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        dma_never = 0;
        hold_len = 4;
        push_random_legal();
        wait_done_cnt(d0 + 1, 40, "timeout_next_done");
        idle_cycles(2);
    endtask

    task automatic test_busy_preexisting();
        int e0;
        int d0;
        e0 = en_cnt;
        d0 = done_cnt;
        dma_force = 1;
        dma_force_val = 1;
        idle_cycles(2);
        push_random_legal();
        idle_cycles(8);
        n_checks += 3;
        if (en_cnt != e0) begin n_fail++; $display("FAIL busy_pre_no_issue: got %0d pulses expected 0", en_cnt - e0); end
        if (count !== 3'd1) begin n_fail++; $display("FAIL busy_pre_count: got %0d expected 1", count); end
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL busy_pre_state: got %0d expected 0", dbg_state); end
        dma_force = 0;
        hold_len = 2;
        wait_done_cnt(d0 + 1, 40, "busy_pre_done");
        n_checks++;
        if (en_cnt != e0 + 1) begin n_fail++; $display("FAIL busy_pre_issue: got %0d pulses expected 1", en_cnt - e0); end
        idle_cycles(2);
    endtask

    task automatic test_reset_midop();
        int e0;
        int d0;
        int n;
        e0 = en_cnt;
        d0 = done_cnt;
        hold_len = 20;
        for (int i = 0; i < DEPTH; i++) push_random_legal();
        n = 0;
        while (dbg_state !== 2'd3 && n < 20) begin
            @(negedge clk);
            n++;
        end
        n_checks += 2;
        if (dbg_state !== 2'd3) begin n_fail++; $display("FAIL midrst_wait_done: got state %0d expected 3", dbg_state); end
        if (count !== 3'd4) begin n_fail++; $display("FAIL midrst_count: got %0d expected 4", count); end
        #2;
        rst_n = 1'b0;
        dma_reset = 1;
        #1;
        n_checks += 6;
        if (count !== '0) begin n_fail++; $display("FAIL midrst_count0: got %0d expected 0", count); end
        if (dma_en !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL midrst_pulses: got en %b done %b expected 0/0", dma_en, done); end
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL midrst_ready: got %b expected 1", cmd_ready); end
        if (queue_busy !== 1'b0) begin n_fail++; $display("FAIL midrst_qbusy: got %b expected 0", queue_busy); end
        if ({funct3, sel_pim, size, mem_addr} !== '0) begin
            n_fail++; $display("FAIL midrst_fields: got %h expected 0", {funct3, sel_pim, size, mem_addr});
        end
        if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL midrst_state: got %0d expected 0", dbg_state); end
        exp_q.delete();
        idle_cycles(2);
        rst_n = 1'b1;
        dma_reset = 0;
        idle_cycles(30);
        n_checks += 2;
        if (done_cnt != d0) begin n_fail++; $display("FAIL midrst_no_done: got %0d expected 0", done_cnt - d0); end
        if (en_cnt != e0 + 1) begin n_fail++; $display("FAIL midrst_no_issue: got %0d pulses expected 1", en_cnt - e0); end
    endtask

    // ---------------------------------------------------------------- sequence/report
    initial begin
        n_checks = 0;
        n_fail = 0;
        rst_n = 1'b0;
        cmd_valid = 1'b0;
        cmd_funct3 = '0;
        cmd_sel_pim = '0;
        cmd_size = '0;
        cmd_mem_addr = '0;
        err_clr = 1'b0;
        dma_force = 0;
        dma_force_val = 0;
        dma_never = 0;
        dma_reset = 0;
        hold_len = 10;

        test_reset();
        test_single_write();
        test_fill();
        test_illegal();
        test_timeout();
        test_busy_preexisting();
        test_reset_midop();

        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_queue: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pim_cmd_queue.md
PIM_CMD_QUEUE -- requirements
Module: pim_cmd_queue

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, command FIFO entries (power of two, >=2).
REQ-002 The block SHALL have parameter BUSY_TIMEOUT, default 15, max cycles allowed in WAIT_BUSY for DMA busy to rise (1..255).
REQ-003 The block SHALL have port i_clk  in  1  clock; all flops on the rising edge.
REQ-004 The block SHALL have port i_rst_n  in  1  reset, asynchronous, active-low.
REQ-005 The block SHALL have port i_cmd_valid  in  1  core presents a PIM command.
REQ-006 The block SHALL have port o_cmd_ready  out  1  queue accepts a command this cycle.
REQ-007 The block SHALL have ports i_cmd_funct3  in  3, i_cmd_sel_pim  in  4, i_cmd_size  in  13, i_cmd_mem_addr  in  32, carrying the command fields.
REQ-008 The block SHALL have port o_dma_en  out  1  one-cycle issue pulse to the DMA.
REQ-009 The block SHALL have ports o_funct3  out  3, o_sel_pim  out  4, o_size  out  13, o_mem_addr  out  32, carrying the head-entry fields to the DMA.
REQ-010 The block SHALL have port i_dma_busy  in  1  DMA transfer in progress.
REQ-011 The block SHALL have port o_done  out  1  one-cycle pulse per completed command.
REQ-012 The block SHALL have port o_err  out  1  sticky error flag.
REQ-013 The block SHALL have port i_err_clr  in  1  synchronous clear of o_err.
REQ-014 The block SHALL have port o_count  out  $clog2(DEPTH)+1  current FIFO occupancy.
REQ-015 The block SHALL have port o_queue_busy  out  1  high when the FIFO is non-empty or the FSM is not IDLE (core fence).

Function
REQ-016 A handshake SHALL occur when i_cmd_valid and o_cmd_ready are both high at a rising edge; o_cmd_ready = (o_count != DEPTH), independent of i_cmd_valid.
REQ-017 An accepted command with funct3 in {001,010,100} and size != 0 SHALL be written at the tail; any other accepted command SHALL be dropped (no enqueue) and SHALL set o_err on the next cycle.
REQ-018 The FIFO SHALL use wrapping read/write pointers of $clog2(DEPTH) bits; on a same-cycle push and pop, o_count SHALL stay unchanged and both pointers SHALL advance.
REQ-019 The FSM SHALL have the states IDLE, ISSUE, WAIT_BUSY and WAIT_DONE, with the transitions below.
  - IDLE -> ISSUE: o_count != 0 and i_dma_busy == 0.
  - ISSUE -> WAIT_BUSY: unconditional after 1 cycle.
  - WAIT_BUSY -> WAIT_DONE: i_dma_busy == 1.
  - WAIT_BUSY -> IDLE: BUSY_TIMEOUT cycles elapse without busy; the head is popped and o_err is set, with no o_done pulse.
  - WAIT_DONE -> IDLE: i_dma_busy == 0; the head is popped and o_done pulses that same cycle.
REQ-020 o_dma_en SHALL be high only in ISSUE, for exactly one cycle per command.
REQ-021 o_funct3, o_sel_pim, o_size and o_mem_addr SHALL drive the head entry while in ISSUE, WAIT_BUSY and WAIT_DONE, and SHALL be 0 in IDLE.
REQ-022 Head fields SHALL NOT change while the FSM is outside IDLE, regardless of pushes.
REQ-023 The wait counter SHALL be 8 bits, cleared on entry to WAIT_BUSY, and incremented each WAIT_BUSY cycle.
REQ-024 Minimum issue-to-issue spacing SHALL be: ISSUE(1) + WAIT_BUSY(>=1) + WAIT_DONE(>=1) + IDLE(1) cycles.
REQ-025 On a push into an empty queue, IDLE SHALL see o_count=1 the next cycle; there SHALL be no bypass, so the earliest o_dma_en is 2 cycles after the handshake.
REQ-026 If i_err_clr and an error-setting event occur in the same cycle, o_err SHALL remain 1 (set wins).
REQ-027 o_done and o_err SHALL be registered or state-decoded only, with no combinational path from i_cmd_* to DMA outputs.

Reset
REQ-028 While i_rst_n is low, all of the following SHALL hold asynchronously: FSM=IDLE, pointers=0, o_count=0, wait counter=0, o_err=0, o_dma_en=0, o_done=0, DMA fields=0, o_queue_busy=0, o_cmd_ready=1.
REQ-029 Reset mid-operation SHALL discard all queued commands without any o_done pulse; FIFO storage need not be reset.

Verification
REQ-030 Single write: push {001, sel=3, size=8, addr=0x100}; DMA model raises busy 1 cycle after en and holds it 10 cycles -> o_dma_en pulses once 2 cycles after push with fields unchanged; o_done pulses on the busy fall; o_count returns 0.
REQ-031 Fill: push 5 legal commands back-to-back with DEPTH=4 while busy is held high -> o_cmd_ready drops after the 4th; the 5th is held; commands issue in FIFO order with no overlap.
REQ-032 Illegal: push funct3=011, then a legal command with size=0 -> both are accepted; o_count stays 0; o_err=1 until i_err_clr; no o_dma_en.
REQ-033 Timeout: DMA model never raises busy -> o_err sets after 15 WAIT_BUSY cycles; the entry is popped; no o_done; the next command issues.
REQ-034 Busy pre-existing: i_dma_busy high with the queue non-empty -> FSM stays IDLE with no o_dma_en until busy falls.
REQ-035 Reset with 3 queued commands while in WAIT_DONE -> all outputs return to reset values immediately; no o_done after release.
